// File: rtl/child_resp_pkg.sv
// rtl/child_resp_pkg.sv - shared types and constants for the child responder
package child_resp_pkg;

  // FSM states of the serialiser.
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_e;

  // Data bits plus one parity bit per frame.
  localparam int FRAME_BITS = 9;

  // One FIFO entry: invert flag and operand byte as captured from the parent.
  typedef struct packed {
    logic       inv;
    logic [7:0] data;
  } entry_t;

  // Byte that actually goes on the wire for a given entry.
  function automatic logic [7:0] tx_byte(entry_t e);
    return e.inv ? ~e.data : e.data;
  endfunction

endpackage

// File: rtl/child_responder_if.sv
// rtl/child_responder_if.sv - child port bundle between parent and responder
interface child_responder_if;
  logic       enable_i;
  logic [7:0] bus_i;
  logic       data_i;
  logic       data_o;
  logic       valid_o;
  logic       full_o;
  logic       ovf_o;

  modport master (
    output enable_i, bus_i, data_i,
    input  data_o, valid_o, full_o, ovf_o
  );

  modport slave (
    input  enable_i, bus_i, data_i,
    output data_o, valid_o, full_o, ovf_o
  );
endinterface

// File: rtl/child_resp_fifo.sv
// rtl/child_resp_fifo.sv - synchronous entry FIFO with registered full/empty
module child_resp_fifo
  import child_resp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  logic   pop_i,
  input  entry_t wdata_i,
  output entry_t rdata_o,
  output logic   empty_o,
  output logic   full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          push_ok, pop_ok;

  // A push into a full FIFO is still taken when the head leaves in the same cycle.
  assign push_ok = push_i && (!full_q || pop_i);
  assign pop_ok  = pop_i && !empty_q;

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
  end

  // Control state; contents are discarded simply by resetting the pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = empty_q;
  assign full_o  = full_q;

endmodule

// File: rtl/child_responder.sv
// rtl/child_responder.sv - buffers parent operands and returns them as parity frames
module child_responder
  import child_resp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  child_responder_if.slave   cp
);

  localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 2);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       par_q, par_d;
  logic       data_q, data_d;
  logic       valid_q, valid_d;
  logic       ovf_q, ovf_d;

  logic       pop;
  logic       fifo_empty;
  logic       fifo_full;
  entry_t     head;
  entry_t     wdata;
  logic [7:0] head_tx;

  assign wdata   = '{inv: cp.data_i, data: cp.bus_i};
  assign head_tx = tx_byte(head);

  child_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (cp.enable_i),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Next-state and next-output logic; outputs describe the bit driven in the coming cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    data_d  = 1'b0;
    valid_d = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE, PARITY: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = head_tx;
          par_d   = ^head_tx;
          cnt_d   = LAST_BIT;
          data_d  = head_tx[7];
          valid_d = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        valid_d = 1'b1;
        if (cnt_q == 3'd0) begin
          data_d  = par_q;
          state_d = PARITY;
        end else begin
          cnt_d   = cnt_q - 3'd1;
          data_d  = shreg_q[cnt_q - 3'd1];
        end
      end
      default: state_d = IDLE;
    endcase
    ovf_d = ovf_q | (cp.enable_i & fifo_full & ~pop);
  end

  // State, shifter and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign cp.data_o  = data_q;
  assign cp.valid_o = valid_q;
  assign cp.full_o  = fifo_full;
  assign cp.ovf_o   = ovf_q;

endmodule

// File: tb/tb_child_responder.sv
// tb/tb_child_responder.sv - scoreboard bench for child_responder
module tb_child_responder;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  child_responder_if tif ();

  child_responder #(.DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .cp     (tif.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: queued entries and the bit stream currently scheduled on the wire.
  logic [8:0] q_m[$];
  bit         cur_m[$];
  bit         ovf_m = 1'b0;
  bit         obs[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each edge retires one wire bit; a new frame starts when the wire is idle or on its parity bit.
  always @(posedge clk or negedge rst_n) begin : model
    int         sz0;
    bit         can_pop;
    logic [8:0] e;
    logic [7:0] b;
    if (!rst_n) begin
      q_m.delete();
      cur_m.delete();
      ovf_m = 1'b0;
    end else begin
      sz0     = q_m.size();
      can_pop = (cur_m.size() <= 1) && (sz0 > 0);
      if (cur_m.size() > 0) void'(cur_m.pop_front());
      if (can_pop) begin
        e = q_m.pop_front();
        b = e[8] ? ~e[7:0] : e[7:0];
        for (int i = 7; i >= 0; i--) cur_m.push_back(b[i]);
        cur_m.push_back(^b);
      end
      if (tif.enable_i) begin
        if (sz0 < DEPTH || can_pop) q_m.push_back({tif.data_i, tif.bus_i});
        else ovf_m = 1'b1;
      end
    end
  end

  // Monitor: compare DUT outputs against the reference on every falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("valid", 32'(tif.valid_o), 32'(cur_m.size() != 0));
      if (cur_m.size() != 0) check("data", 32'(tif.data_o), 32'(cur_m[0]));
      check("full", 32'(tif.full_o), 32'(q_m.size() == DEPTH));
      check("ovf", 32'(tif.ovf_o), 32'(ovf_m));
      if (tif.valid_o) obs.push_back(tif.data_o);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic pushes(input logic [7:0] bytes[$], input bit invs[$]);
    for (int i = 0; i < bytes.size(); i++) begin
      @(negedge clk);
      tif.enable_i = 1'b1;
      tif.bus_i    = bytes[i];
      tif.data_i   = invs[i];
    end
    @(negedge clk);
    tif.enable_i = 1'b0;
  endtask

  task automatic drain(string name);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (cur_m.size() == 0 && q_m.size() == 0) done = 1'b1;
    end
    check({name, "_drain"}, 32'(done), 32'd1);
    @(negedge clk);
  endtask

  function automatic logic [31:0] obs_word(int first, int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[30:0], obs[first + i]};
    return v;
  endfunction

  initial begin
    logic [7:0] bl[$];
    bit         il[$];
    bit         hit;

    tif.enable_i = 1'b0;
    tif.bus_i    = '0;
    tif.data_i   = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(tif.valid_o), 32'd0);
    check("rst_data", 32'(tif.data_o), 32'd0);
    check("rst_full", 32'(tif.full_o), 32'd0);
    check("rst_ovf", 32'(tif.ovf_o), 32'd0);
    #2 rst_n = 1'b1;

    // Single frame A5.
    obs.delete();
    bl = '{8'hA5}; il = '{1'b0};
    pushes(bl, il);
    drain("a5");
    check("a5_len", 32'(obs.size()), 32'd9);
    check("a5_bits", obs_word(0, 9), 32'h14A);

    // Inverted 0F is sent as F0.
    obs.delete();
    bl = '{8'h0F}; il = '{1'b1};
    pushes(bl, il);
    drain("inv");
    check("inv_len", 32'(obs.size()), 32'd9);
    check("inv_bits", obs_word(0, 9), 32'h1E0);

    // Back-to-back frames run without a gap.
    obs.delete();
    bl = '{8'h01, 8'h80}; il = '{1'b0, 1'b0};
    pushes(bl, il);
    drain("b2b");
    check("b2b_len", 32'(obs.size()), 32'd18);
    check("b2b_par0", 32'(obs[8]), 32'd1);
    check("b2b_par1", 32'(obs[17]), 32'd1);

    // Overflow: six pushes into a depth-four FIFO.
    obs.delete();
    bl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    il = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    pushes(bl, il);
    check("ovf_set", 32'(tif.ovf_o), 32'd1);
    check("ovf_full", 32'(tif.full_o), 32'd1);
    drain("ovf");
    check("ovf_len", 32'(obs.size()), 32'd45);
    check("ovf_sticky", 32'(tif.ovf_o), 32'd1);

    // Full FIFO plus a push landing on the popping parity cycle.
    do_reset();
    check("ovf_cleared", 32'(tif.ovf_o), 32'd0);
    bl = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A}; il = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    pushes(bl, il);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if (cur_m.size() == 1 && q_m.size() == DEPTH) begin
        hit = 1'b1;
        tif.enable_i = 1'b1;
        tif.bus_i    = 8'hC3;
        tif.data_i   = 1'b0;
      end
    end
    check("fullpop_reached", 32'(hit), 32'd1);
    @(negedge clk);
    tif.enable_i = 1'b0;
    check("fullpop_ovf", 32'(tif.ovf_o), 32'd0);
    check("fullpop_full", 32'(tif.full_o), 32'd1);
    drain("fullpop");

    // Reset in the middle of a frame with two entries queued.
    bl = '{8'hAA, 8'hBB, 8'hCC}; il = '{1'b0, 1'b0, 1'b0};
    pushes(bl, il);
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge clk);
      if (cur_m.size() == 5 && q_m.size() == 2) hit = 1'b1;
    end
    check("midrst_reached", 32'(hit), 32'd1);
    check("midrst_busy", 32'(tif.valid_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(tif.valid_o), 32'd0);
    check("midrst_data", 32'(tif.data_o), 32'd0);
    check("midrst_full", 32'(tif.full_o), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    obs.delete();
    repeat (30) @(negedge clk);
    check("midrst_noframes", 32'(obs.size()), 32'd0);
    check("midrst_full_after", 32'(tif.full_o), 32'd0);

    // Random traffic, including bursts that overflow.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      tif.enable_i = ($urandom_range(0, 4) == 0);
      tif.bus_i    = 8'($urandom);
      tif.data_i   = 1'($urandom);
    end
    @(negedge clk);
    tif.enable_i = 1'b0;
    drain("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/child_responder.md
# child_responder

Responder end of the child port bundle: accepts enable-qualified 8-bit operands from a parent instance, buffers them in a small FIFO, and returns each one as a serial frame on `data_o`, qualified by `valid_o`. A frame is 8 data bits (MSB first) followed by one even-parity bit. The block sits under any parent that drives `enable_i`/`bus_i`/`data_i`, and it needs no flow control back to that parent.

## Interface
- `DEPTH`, default 4: FIFO entries; a power of two, ≥ 2.
- `clk_i`, input, 1: single clock; all logic on the rising edge.
- `rst_ni`, input, 1: reset, asynchronous and active-low.
- `enable_i`, input, 1: push strobe; one entry is captured per cycle it is high.
- `bus_i`, input, 8: operand byte, sampled with `enable_i`.
- `data_i`, input, 1: invert flag, sampled with `enable_i`. When 1, the byte is complemented before transmission.
- `data_o`, output, 1: serial frame bit.
- `valid_o`, output, 1: high on every cycle that `data_o` carries a frame bit.
- `full_o`, output, 1: FIFO holds `DEPTH` entries.
- `ovf_o`, output, 1: sticky; set when a push is dropped; cleared only by reset.

## Operation
- Push: `enable_i`=1 at an edge writes `{data_i, bus_i}` into the FIFO.
  - If the FIFO is full and no pop happens in the same cycle, the push is dropped and `ovf_o` is set.
  - If the FIFO is full and a pop happens in the same cycle, the push is accepted.
- Pop: the FSM pops the head entry and loads the shift register with `byte = data_i ? ~bus_i : bus_i`.
  - The parity bit is `^byte`, computed on the transmitted byte.
- FSM states:
  - IDLE: `valid_o`=0, `data_o`=0. If the FIFO is not empty → pop, go to SHIFT, bit counter = 7.
  - SHIFT: drive `byte[cnt]` with `valid_o`=1. Decrement the counter; after bit 0 → PARITY.
  - PARITY: drive the parity bit with `valid_o`=1.
    - FIFO not empty → pop in this same cycle and go to SHIFT (no gap between frames).
    - FIFO empty → IDLE.
- Every frame is exactly 9 consecutive `valid_o` cycles. `valid_o` never drops mid-frame.
- Counter and pointer widths: `$clog2(DEPTH)` for pointers, plus 1 extra bit for the occupancy count. Pointers wrap modulo `DEPTH`.

## Timing
- Reset values:
  - `data_o`=0, `valid_o`=0, `full_o`=0, `ovf_o`=0.
  - FSM=IDLE, FIFO empty, pointers=0.
- Reset asserted mid-frame aborts the frame immediately: `valid_o`=0 asynchronously, and FIFO contents are discarded.
- Latency from an idle, empty block:
  - Push at edge t0; pop at edge t1; bit 7 is on `data_o`/`valid_o` from t1 to t2.
  - The parity bit occupies t9 to t10.
- `full_o` is registered and updates at the edge that changes occupancy.
- `ovf_o` rises at the edge of the dropped push.
- All outputs are registered; there is no combinational input→output path.

## Structure
- Package `child_resp_pkg` holds:
  - the `state_e` enum {IDLE, SHIFT, PARITY};
  - `FRAME_BITS`=9;
  - the entry typedef `struct packed {logic inv; logic [7:0] byte;}`.
- Sub-module `child_resp_fifo` is a synchronous FIFO parameterised by `DEPTH`.
  - Ports: push, pop, wdata, rdata, empty, full.
  - Simultaneous push and pop when full is legal.
- Top-level `child_responder` contains the FSM, shift register, parity generation and the overflow flag.

## Test plan
- Single push, `bus_i`=8'hA5, `data_i`=0 → after 1 idle cycle, 9 `valid_o` cycles with `data_o` = 1,0,1,0,0,1,0,1, then parity 0.
- Invert: `bus_i`=8'h0F, `data_i`=1 → bits 1,1,1,1,0,0,0,0, then parity 0.
- Back-to-back: pushes 8'h01 then 8'h80 on consecutive cycles → 18 contiguous `valid_o` cycles.
  - Parity bits 1 then 1.
  - No gap between frames.
- Overflow, `DEPTH`=4: 6 consecutive pushes starting from idle.
  - One entry is popped at t1, so `full_o` rises after the 5th push.
  - The 6th push is dropped and `ovf_o`=1.
  - Exactly 5 frames follow.
  - `ovf_o` stays 1 until reset.
- Full with simultaneous pop: fill the FIFO, then push in the PARITY cycle that pops → push accepted, `ovf_o` stays 0.
- Reset mid-frame: assert `rst_ni`=0 at bit 3 of a frame with 2 entries queued.
  - Outputs go to 0 at once.
  - After release: no frames, `full_o`=0.
